// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display driver: digit codes, FSM
// encoding, seven-segment glyphs and the BCD adjust step.
package calc_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  typedef logic [4:0] code_t;
  typedef code_t [3:0] disp_t;

  localparam code_t CODE_DASH  = 5'd16;
  localparam code_t CODE_BLANK = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Active-low segments, bit order g..a
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Entry 15 (F) is listed first so GLYPH_HEX[n] is the glyph for n
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'b0001110,
    7'b0000110,
    7'b0100001,
    7'b1000110,
    7'b0000011,
    7'b0001000,
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational digit-code to active-low seven-segment glyph decoder.
module sseg_decode
  import calc_pkg::*;
(
  input  code_t      code,
  output logic [6:0] glyph
);

  // NOTE: assign a default first so every path drives glyph and no latch is inferred.
  always_comb begin
    glyph = GLYPH_BLANK;
    if (code < 5'd16) glyph = GLYPH_HEX[code[3:0]];
    else if (code == CODE_DASH) glyph = GLYPH_DASH;
  end

endmodule

// File: rtl/calc_display.sv
// Four-digit multiplexed display driver: snapshots the accumulator, converts it
// to signed decimal (double dabble) or hex, and scans the result onto the digits.
module calc_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        dec_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        busy
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state;
  logic [15:0] snap_val;
  logic        snap_mode;
  logic        snap_ok;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [3:0]  count;
  disp_t       disp;
  disp_t       fmt;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [6:0]       glyph;

  // Formatter: pure function of the snapshot and the finished BCD value
  logic neg;
  logic in_range;
  logic z3, z32, z321;

  always_comb begin
    neg      = snap_val[15];
    in_range = neg ? (bcd[19:12] == 8'd0) : (bcd[19:16] == 4'd0);
    z3       = (bcd[15:12] == 4'd0);
    z32      = z3 && (bcd[11:8] == 4'd0);
    z321     = z32 && (bcd[7:4] == 4'd0);
    fmt      = {4{CODE_DASH}};
    if (!snap_mode) begin
      for (int i = 0; i < 4; i++) fmt[i] = {1'b0, snap_val[4*i +: 4]};
    end else if (in_range) begin
      fmt[3] = neg ? CODE_DASH : (z3 ? CODE_BLANK : {1'b0, bcd[15:12]});
      fmt[2] = z32  ? CODE_BLANK : {1'b0, bcd[11:8]};
      fmt[1] = z321 ? CODE_BLANK : {1'b0, bcd[7:4]};
      fmt[0] = {1'b0, bcd[3:0]};
    end
  end

  // Converter FSM. The snapshot is what gets formatted, so inputs that move
  // mid-conversion never leak into disp; IDLE notices the mismatch afterwards.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      snap_val  <= '0;
      snap_mode <= 1'b0;
      snap_ok   <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      // NOTE: disp is a handful of flops that must come up blank, so it is reset like any register.
      disp      <= {4{CODE_BLANK}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (!snap_ok || value != snap_val || dec_mode != snap_mode) begin
            snap_val  <= value;
            snap_mode <= dec_mode;
            snap_ok   <= 1'b1;
            busy      <= 1'b1;
            if (dec_mode) begin
              mag   <= value[15] ? (~value + 16'd1) : value;
              bcd   <= '0;
              count <= '0;
              state <= ST_SHIFT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          {bcd, mag} <= {bcd_adjust(bcd), mag} << 1;
          count      <= count + 4'd1;
          if (count == 4'd15) state <= ST_DONE;
        end
        ST_DONE: begin
          disp  <= fmt;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sseg_decode u_decode (
    .code  (disp[idx]),
    .glyph (glyph)
  );

  // Scanner runs free of the converter; an and seg are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= 2'd0;
      an  <= 4'b1110;
      seg <= GLYPH_BLANK;
    end else begin
      if (div == DIV_W'(REFRESH_DIV - 1)) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= glyph;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: conversion latency, decimal/hex formatting,
// scan order, and mid-conversion input changes and resets.
module tb_calc_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        dec_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  calc_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dec_mode (dec_mode),
    .an       (an),
    .seg      (seg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] char_glyph(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "b": return 7'h03;
      "E": return 7'h06;
      "F": return 7'h0E;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Sample n cycles of the scan, filing each seg value under the digit an selects
  task automatic scan(input int n, output logic [3:0][6:0] segs, output logic [3:0] seen,
                      output logic bad);
    segs = '1;
    seen = '0;
    bad  = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin segs[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin segs[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin segs[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin segs[3] = seg; seen[3] = 1'b1; end
        default: bad = 1'b1;
      endcase
    end
  endtask

  task automatic compare_display(input string tag, input string s,
                                 input logic [3:0][6:0] segs, input logic [3:0] seen,
                                 input logic bad);
    check({tag, "_an_valid"}, bad, 1'b0);
    check({tag, "_seen"}, seen, 4'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_d%0d", tag, i), segs[i], char_glyph(s[3-i]));
  endtask

  task automatic check_display(input string tag, input string s);
    logic [3:0][6:0] segs;
    logic [3:0]      seen;
    logic            bad;
    @(negedge clk);
    scan(16, segs, seen, bad);
    compare_display(tag, s, segs, seen, bad);
  endtask

  // Wait (bounded) for busy to rise, then count how many cycles it stays high
  task automatic conv_len(input string tag, input int exp_len);
    int n = 0;
    int guard = 0;
    @(negedge clk);
    while (!busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_len);
  endtask

  logic [15:0] dv [8] = '{16'd1234, 16'd9999, 16'd10000, 16'd7,
                          16'hFF85, 16'hFFFB, 16'hFC18, 16'h8000};
  string       ds [8] = '{"1234", "9999", "----", "   7",
                          "-123", "-  5", "----", "----"};

  initial begin
    logic [3:0][6:0] segs;
    logic [3:0]      seen;
    logic            bad;
    logic [3:0]      prev;
    logic [3:0]      a0;
    logic [3:0]      exp_an;
    int              n;
    int              guard;

    rst      = 1'b1;
    value    = 16'd0;
    dec_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1111111);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    conv_len("zero_len", 17);
    check_display("zero", "   0");

    for (int i = 0; i < 8; i++) begin
      value = dv[i];
      conv_len($sformatf("dec%0d_len", i), 17);
      check_display($sformatf("dec%0d", i), ds[i]);
    end

    dec_mode = 1'b0;
    value    = 16'hBEEF;
    conv_len("hex_len", 1);
    check_display("hex", "bEEF");
    dec_mode = 1'b1;
    conv_len("hex2dec_len", 17);
    check_display("hex2dec", "----");
    dec_mode = 1'b0;
    conv_len("dec2hex_len", 1);
    check_display("dec2hex", "bEEF");

    // Scan order: after an edge of an, each digit is held 4 cycles, rotating left
    @(negedge clk);
    prev  = an;
    guard = 0;
    while (an == prev && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    a0 = an;
    for (int j = 0; j < 16; j++) begin
      exp_an = a0;
      for (int r = 0; r < j / 4; r++) exp_an = {exp_an[2:0], exp_an[3]};
      check($sformatf("scan_an%0d", j), an, exp_an);
      @(negedge clk);
    end

    // Value changes 1 -> 2 during the fifth cycle of a conversion
    value    = 16'd1;
    dec_mode = 1'b1;
    n        = 0;
    guard    = 0;
    @(negedge clk);
    while (!busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    while (busy && n < 100) begin
      n++;
      if (n == 5) value = 16'd2;
      @(negedge clk);
    end
    check("mid_len1", n, 17);
    @(negedge clk);
    check("mid_restart", busy, 1'b1);
    scan(16, segs, seen, bad);
    compare_display("mid1", "   1", segs, seen, bad);
    @(negedge clk);
    check("mid_done2", busy, 1'b0);
    check_display("mid2", "   2");

    // Reset during the eighth cycle of a conversion
    value = 16'd5;
    n     = 0;
    guard = 0;
    @(negedge clk);
    while (!busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n = 1;
    while (n < 8) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", an, 4'b1110);
    check("midrst_seg", seg, 7'b1111111);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_restart", busy, 1'b1);
    scan(16, segs, seen, bad);
    compare_display("rst_blank", "    ", segs, seen, bad);
    @(negedge clk);
    check("rst_done", busy, 1'b0);
    check_display("rst5", "   5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
